bx_sequencer: RTL and testbench



---
 rtl/bx_seq_pkg.sv | 12 +
 rtl/bx_sequencer_rr_arbiter.sv | 35 +++
 rtl/bx_sequencer.sv | 151 +++++++++++++++
 tb/tb_bx_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bx_seq_pkg.sv
// Shared constants and types for the BX sequencer.
package bx_seq_pkg;

  localparam int BX_PER_ORBIT_LHC = 3564;
  localparam int PHASE_WIDTH      = 2;

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bx_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (mod N_REQ)
// for the first asserted request. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // First-hit search starting just above the last winner.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = IDX_W'((int'(ptr) + k) % N_REQ);
      if (en && !found_s && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/bx_sequencer.sv
// BX/orbit timing sequencer with 40/80 MHz strobes and a per-BX round-robin slot grant.
// Optional BC0-mismatch error counter enabled by defining BX_SEQ_ERR_COUNT_EN.
module bx_sequencer
  import bx_seq_pkg::*;
#(
  parameter int BX_PER_ORBIT = BX_PER_ORBIT_LHC,
  parameter int BX_WIDTH     = 12,
  parameter int ORBIT_WIDTH  = 16,
  parameter int PHASE_OFFSET = 3,
  parameter int N_REQ        = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   resync_i,
  input  logic                   bc0_i,
  input  logic [N_REQ-1:0]       req_i,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic                   strobe40_o,
  output logic                   strobe80_o,
  output logic [BX_WIDTH-1:0]    bx_o,
  output logic [ORBIT_WIDTH-1:0] orbit_o,
  output logic                   bc0_o,
  output logic                   locked_o,
  output logic [N_REQ-1:0]       gnt_o
`ifdef BX_SEQ_ERR_COUNT_EN
  ,output logic [7:0]            err_count_o
`endif
);

  localparam int                     IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [BX_WIDTH-1:0]    BX_LAST  = BX_WIDTH'(BX_PER_ORBIT - 1);
  localparam logic [PHASE_WIDTH-1:0] PH_OFF   = PHASE_WIDTH'(PHASE_OFFSET);
  localparam logic [IDX_W-1:0]       PTR_INIT = IDX_W'(N_REQ - 1);

  logic [PHASE_WIDTH-1:0] phase_r;
  state_t                 state_r;
  logic [BX_WIDTH-1:0]    bx_r;
  logic [ORBIT_WIDTH-1:0] orbit_r;
  logic [N_REQ-1:0]       gnt_r;
  logic [IDX_W-1:0]       ptr_r;

  logic                   strobe40_s;
  logic                   bx_last_s;
  logic                   arb_en_s;
  logic [N_REQ-1:0]       arb_gnt_s;
  logic [IDX_W-1:0]       arb_idx_s;

  assign strobe40_s = (phase_r == PH_OFF);
  assign bx_last_s  = (bx_r == BX_LAST);
  assign arb_en_s   = strobe40_s && (state_r == RUN);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req_i),
    .ptr (ptr_r),
    .en  (arb_en_s),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  // Free-running 160 MHz phase; only reset touches it.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_r <= '0;
    end else begin
      phase_r <= phase_r + PHASE_WIDTH'(1'b1);
    end
  end

`ifdef BX_SEQ_ERR_COUNT_EN
  logic [7:0] err_r;
  assign err_count_o = err_r;
`endif

  // Lock FSM, BX/orbit counters and grant register; resync outranks a BC0 mismatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= SYNC;
      bx_r    <= '0;
      orbit_r <= '0;
      gnt_r   <= '0;
      ptr_r   <= PTR_INIT;
`ifdef BX_SEQ_ERR_COUNT_EN
      err_r   <= 8'd0;
`endif
    end else if (resync_i) begin
      state_r <= SYNC;
      bx_r    <= '0;
      orbit_r <= '0;
      gnt_r   <= '0;
    end else if (strobe40_s) begin
      case (state_r)
        SYNC: begin
          state_r <= bc0_i ? RUN : SYNC;
          bx_r    <= '0;
          orbit_r <= '0;
          gnt_r   <= '0;
        end
        RUN: begin
          if (bc0_i && !bx_last_s) begin
            state_r <= SYNC;
            bx_r    <= '0;
            orbit_r <= '0;
            gnt_r   <= '0;
`ifdef BX_SEQ_ERR_COUNT_EN
            if (err_r != 8'hFF) begin
              err_r <= err_r + 8'd1;
            end else begin
              err_r <= err_r;
            end
`endif
          end else begin
            state_r <= RUN;
            if (bx_last_s) begin
              bx_r    <= '0;
              orbit_r <= orbit_r + ORBIT_WIDTH'(1'b1);
            end else begin
              bx_r    <= bx_r + BX_WIDTH'(1'b1);
            end
            gnt_r <= arb_gnt_s;
            if (|arb_gnt_s) begin
              ptr_r <= arb_idx_s;
            end else begin
              ptr_r <= ptr_r;
            end
          end
        end
        default: begin
          state_r <= SYNC;
          bx_r    <= '0;
          orbit_r <= '0;
          gnt_r   <= '0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign phase_o    = phase_r;
  assign strobe40_o = strobe40_s;
  assign strobe80_o = (phase_r[0] == PH_OFF[0]);
  assign bx_o       = bx_r;
  assign orbit_o    = orbit_r;
  assign gnt_o      = gnt_r;
  assign locked_o   = (state_r == RUN);
  assign bc0_o      = (state_r == RUN) && (bx_r == '0);

endmodule

// File: tb/tb_bx_sequencer.sv
// Directed self-checking bench for bx_sequencer; outputs sampled on the falling edge.
module tb_bx_sequencer;

  logic        clock;
  logic        reset;
  logic        resync;
  logic        bc0;
  logic [3:0]  req;
  logic [1:0]  phase;
  logic        strobe40;
  logic        strobe80;
  logic [11:0] bx;
  logic [15:0] orbit;
  logic        bc0_out;
  logic        locked;
  logic [3:0]  gnt;
`ifdef BX_SEQ_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int checks   = 0;
  int failures = 0;

  bx_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .resync_i   (resync),
    .bc0_i      (bc0),
    .req_i      (req),
    .phase_o    (phase),
    .strobe40_o (strobe40),
    .strobe80_o (strobe80),
    .bx_o       (bx),
    .orbit_o    (orbit),
    .bc0_o      (bc0_out),
    .locked_o   (locked),
    .gnt_o      (gnt)
`ifdef BX_SEQ_ERR_COUNT_EN
    ,.err_count_o (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Advance to the next sample where strobe40 is high (the cycle before a strobe edge).
  task automatic wait_strobe();
    int n;
    n = 0;
    tick();
    while (!strobe40 && n < 8) begin
      tick();
      n++;
    end
    check("wait_strobe40", {31'd0, strobe40}, 32'd1);
  endtask

  // Advance to the strobe40 sample whose BX equals target.
  task automatic wait_bx(input logic [11:0] target);
    int n;
    n = 0;
    tick();
    while (!(strobe40 && bx == target) && n < 20000) begin
      tick();
      n++;
    end
    check("wait_bx", {20'd0, bx}, {20'd0, target});
  endtask

  logic [3:0] exp_gnt [5];

  initial begin
    exp_gnt[0] = 4'b0001;
    exp_gnt[1] = 4'b0010;
    exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000;
    exp_gnt[4] = 4'b0001;
    reset  = 1'b1;
    resync = 1'b0;
    bc0    = 1'b0;
    req    = 4'b0000;
    repeat (3) tick();

    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_bx", {20'd0, bx}, 32'd0);
    check("rst_orbit", {16'd0, orbit}, 32'd0);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_bc0", {31'd0, bc0_out}, 32'd0);
    check("rst_s40", {31'd0, strobe40}, 32'd0);
    check("rst_s80", {31'd0, strobe80}, 32'd0);

    // Phase sequence and strobe decode after release.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("phase_seq", {30'd0, phase}, i % 4);
      check("s40_seq", {31'd0, strobe40}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      check("s80_seq", {31'd0, strobe80}, ((i % 2) == 1) ? 32'd1 : 32'd0);
      check("sync_locked", {31'd0, locked}, 32'd0);
      check("sync_bx", {20'd0, bx}, 32'd0);
      if (i < 7) tick();
    end

    // Lock on BC0.
    bc0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      bc0 = 1'b0;
      check("lock_locked", {31'd0, locked}, 32'd1);
      check("lock_bx", {20'd0, bx}, 32'd0);
      check("lock_bc0_out", {31'd0, bc0_out}, 32'd1);
    end
    tick();
    check("bx1_bx", {20'd0, bx}, 32'd1);
    check("bx1_bc0_out", {31'd0, bc0_out}, 32'd0);

    // Orbit wrap with no BC0 at the boundary.
    wait_bx(12'd3563);
    check("pre_wrap_orbit", {16'd0, orbit}, 32'd0);
    tick();
    check("wrap_bx", {20'd0, bx}, 32'd0);
    check("wrap_orbit", {16'd0, orbit}, 32'd1);
    check("wrap_bc0_out", {31'd0, bc0_out}, 32'd1);
    check("wrap_locked", {31'd0, locked}, 32'd1);

    // Round-robin with all requesters active.
    wait_strobe();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check("rr_all", {28'd0, gnt}, {28'd0, exp_gnt[g]});
      end
    end
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      check("rr_single_held", {28'd0, gnt}, 32'h4);
    end
    tick();
    check("rr_none", {28'd0, gnt}, 32'd0);
    wait_strobe();
    req = 4'b1111;
    tick();
    check("rr_ptr_kept", {28'd0, gnt}, 32'h8);
    req = 4'b0000;

    // BC0 mismatch at BX 100.
    wait_bx(12'd100);
    bc0 = 1'b1;
    tick();
    bc0 = 1'b0;
    check("mm_locked", {31'd0, locked}, 32'd0);
    check("mm_bx", {20'd0, bx}, 32'd0);
    check("mm_orbit", {16'd0, orbit}, 32'd0);
    check("mm_gnt", {28'd0, gnt}, 32'd0);
`ifdef BX_SEQ_ERR_COUNT_EN
    check("mm_err", {24'd0, err_count}, 32'd1);
`endif
    req = 4'b1111;
    wait_strobe();
    tick();
    check("sync_no_gnt", {28'd0, gnt}, 32'd0);
    check("sync_stay", {31'd0, locked}, 32'd0);

    // Relock; pointer from before the mismatch (3) is kept.
    wait_strobe();
    bc0 = 1'b1;
    tick();
    bc0 = 1'b0;
    check("relock", {31'd0, locked}, 32'd1);
    check("relock_gnt", {28'd0, gnt}, 32'd0);
    wait_strobe();
    tick();
    check("relock_first_gnt", {28'd0, gnt}, 32'h1);
    check("relock_bx", {20'd0, bx}, 32'd1);

    // Resync and BC0 together: resync wins, no error count.
    wait_strobe();
    resync = 1'b1;
    bc0    = 1'b1;
    tick();
    resync = 1'b0;
    bc0    = 1'b0;
    check("rs_locked", {31'd0, locked}, 32'd0);
    check("rs_bx", {20'd0, bx}, 32'd0);
    check("rs_gnt", {28'd0, gnt}, 32'd0);
`ifdef BX_SEQ_ERR_COUNT_EN
    check("rs_err", {24'd0, err_count}, 32'd1);
`endif
    wait_strobe();
    bc0 = 1'b1;
    tick();
    bc0 = 1'b0;
    check("rs_relock", {31'd0, locked}, 32'd1);
    wait_strobe();
    tick();
    check("rs_ptr_kept", {28'd0, gnt}, 32'h2);

    // Reset mid-grant.
    reset = 1'b1;
    tick();
    check("mid_rst_phase", {30'd0, phase}, 32'd0);
    check("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    check("mid_rst_bx", {20'd0, bx}, 32'd0);
    check("mid_rst_orbit", {16'd0, orbit}, 32'd0);
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_bc0", {31'd0, bc0_out}, 32'd0);
    check("mid_rst_s40", {31'd0, strobe40}, 32'd0);
`ifdef BX_SEQ_ERR_COUNT_EN
    check("mid_rst_err", {24'd0, err_count}, 32'd0);
`endif
    reset = 1'b0;
    wait_strobe();
    bc0 = 1'b1;
    tick();
    bc0 = 1'b0;
    check("post_rst_lock", {31'd0, locked}, 32'd1);
    wait_strobe();
    tick();
    check("post_rst_gnt", {28'd0, gnt}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
